// File: rtl/sd_pkg.sv
//==============================================================================
// sd_pkg - shared SD delay-arbiter state encoding and defaults | rev 1.0
//==============================================================================
`default_nettype none

package sd_pkg;

  localparam int SD_DLY_COUNT_SIZE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [2:0] rr_next(input logic [2:0] id, input int n);
    return (32'(id) >= n - 1) ? 3'd0 : id + 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_delay_arbiter_if.sv
//==============================================================================
// sd_delay_arbiter_if - requester bundle plus delay-engine start/finish link | rev 1.0
//==============================================================================
`default_nettype none

interface sd_delay_arbiter_if
  import sd_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int COUNT_SIZE = SD_DLY_COUNT_SIZE
);

  logic [N_REQ-1:0]            req;
  logic [N_REQ*COUNT_SIZE-1:0] req_times;
  logic [N_REQ-1:0]            ack;
  logic                        busy;
  logic [2:0]                  grant_id;
  logic                        dly_start;
  logic [COUNT_SIZE-1:0]       dly_times;
  logic                        dly_finish;
  logic                        err;

  modport master (
    output req, req_times, dly_finish,
    input  ack, busy, grant_id, dly_start, dly_times, err
  );

  modport slave (
    input  req, req_times, dly_finish,
    output ack, busy, grant_id, dly_start, dly_times, err
  );

endinterface

`default_nettype wire

// File: rtl/sd_rr_pick.sv
//==============================================================================
// sd_rr_pick - combinational first-set-bit finder starting at ptr (mod N_REQ) | rev 1.0
//==============================================================================
`default_nettype none

module sd_rr_pick
  import sd_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             valid,
  output logic [2:0]       idx
);

  always_comb begin
    int j;
    valid = 1'b0;
    idx   = 3'd0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = 3'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sd_delay_arbiter.sv
//==============================================================================
// sd_delay_arbiter - round-robin share of one SD delay engine; option SD_DLY_TIMEOUT_EN | rev 1.0
//==============================================================================
`default_nettype none

module sd_delay_arbiter
  import sd_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int COUNT_SIZE = SD_DLY_COUNT_SIZE,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  sd_delay_arbiter_if.slave  bus
);

  state_t     state;
  logic [2:0] ptr;
  logic       pick_valid;
  logic [2:0] pick_idx;

  sd_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req & ~bus.ack),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef SD_DLY_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign bus.err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ptr           <= 3'd0;
      bus.ack       <= '0;
      bus.busy      <= 1'b0;
      bus.grant_id  <= 3'd0;
      bus.dly_start <= 1'b0;
      bus.dly_times <= '0;
`ifdef SD_DLY_TIMEOUT_EN
      wd_cnt        <= '0;
      bus.err       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            bus.grant_id  <= pick_idx;
            bus.dly_times <= bus.req_times[32'(pick_idx)*COUNT_SIZE +: COUNT_SIZE];
            bus.dly_start <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= ST_ARM;
`ifdef SD_DLY_TIMEOUT_EN
            wd_cnt        <= '0;
`endif
          end
        end
        ST_ARM: begin
`ifdef SD_DLY_TIMEOUT_EN
          wd_cnt <= wd_cnt + 1'b1;
          if (wd_hit) begin
            bus.dly_start          <= 1'b0;
            bus.err                <= 1'b1;
            bus.ack[bus.grant_id]  <= 1'b1;
            state                  <= ST_DONE;
          end else
`endif
          // a finish level still high here belongs to the previous run
          if (!bus.dly_finish) state <= ST_RUN;
        end
        ST_RUN: begin
`ifdef SD_DLY_TIMEOUT_EN
          wd_cnt <= wd_cnt + 1'b1;
          if (wd_hit) begin
            bus.dly_start          <= 1'b0;
            bus.err                <= 1'b1;
            bus.ack[bus.grant_id]  <= 1'b1;
            state                  <= ST_DONE;
          end else
`endif
          if (bus.dly_finish) begin
            bus.ack[bus.grant_id] <= 1'b1;
            bus.dly_start         <= 1'b0;
            state                 <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!bus.req[bus.grant_id]) begin
            bus.ack  <= '0;
            bus.busy <= 1'b0;
            ptr      <= rr_next(bus.grant_id, N_REQ);
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sd_delay_arbiter.sv
//==============================================================================
// tb_sd_delay_arbiter - vector table + scoreboard bench with a behavioural delay engine | rev 1.0
//==============================================================================
`default_nettype none

module tb_sd_delay_arbiter;
  import sd_pkg::*;

  localparam int N  = 3;
  localparam int CS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sd_delay_arbiter_if #(.N_REQ(N), .COUNT_SIZE(CS)) bus();

  sd_delay_arbiter #(.N_REQ(N), .COUNT_SIZE(CS), .TIMEOUT(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // engine: finish rises times+1 cycles after start, clears once start drops
  logic [CS-1:0] e_cnt;
  logic          e_fin;
  logic          stale_fin = 1'b0;
  logic          stuck     = 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_cnt <= '0;
      e_fin <= 1'b0;
    end else if (!bus.dly_start || stale_fin || stuck) begin
      e_cnt <= '0;
      e_fin <= 1'b0;
    end else if (!e_fin) begin
      if (e_cnt == bus.dly_times) e_fin <= 1'b1;
      else                        e_cnt <= e_cnt + 1'b1;
    end
  end
  assign bus.dly_finish = e_fin | stale_fin;

  typedef struct {
    int            id;
    logic [CS-1:0] t;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [N-1:0]    req;
    logic [N*CS-1:0] times;
  } vec_t;
  vec_t vecs[5];

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_grants(input logic [N-1:0] mask, input logic [N*CS-1:0] times);
    logic [N-1:0] m;
    int p;
    m = mask;
    p = ptr_m;
    while (m != 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (p + k) % N;
        if (m[j]) begin
          sbq.push_back('{j, times[j*CS +: CS]});
          m[j] = 1'b0;
          p = (j + 1) % N;
          break;
        end
      end
    end
  endtask

  task automatic wait_ack(output bit ok);
    int n;
    n = 0;
    while (bus.ack == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.ack != 0);
    if (!ok) chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (!bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.busy) chk("busy_timeout", 0, 1);
  endtask

  task automatic serve_one(input bit more);
    exp_t e;
    bit   ok;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 0, 1);
      return;
    end
    e = sbq.pop_front();
    wait_ack(ok);
    if (!ok) return;
    chk("ack_onehot", int'(bus.ack), 1 << e.id);
    chk("grant_id", int'(bus.grant_id), e.id);
    chk("dly_times", int'(bus.dly_times), int'(e.t));
    chk("start_low_at_ack", int'(bus.dly_start), 0);
    chk("busy_at_ack", int'(bus.busy), 1);
    chk("err_low", int'(bus.err), 0);
    bus.req[e.id] = 1'b0;
    @(negedge clk);
    chk("ack_drop", int'(bus.ack), 0);
    chk("idle_gap", int'(bus.busy), 0);
    ptr_m = (e.id + 1) % N;
    if (more) begin
      @(negedge clk);
      chk("regrant", int'(bus.busy), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    bus.req       = '0;
    bus.req_times = '0;

    vecs[0] = '{3'b111, {4'd6, 4'd4, 4'd2}};
    vecs[1] = '{3'b010, {4'd0, 4'd5, 4'd0}};
    vecs[2] = '{3'b101, {4'd3, 4'd0, 4'd1}};
    vecs[3] = '{3'b001, 12'h000};
    vecs[4] = '{3'b110, {4'd3, 4'd15, 4'd0}};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_grant_id", int'(bus.grant_id), 0);
    chk("rst_dly_start", int'(bus.dly_start), 0);
    chk("rst_dly_times", int'(bus.dly_times), 0);
    chk("rst_err", int'(bus.err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      bus.req_times = vecs[v].times;
      push_grants(vecs[v].req, vecs[v].times);
      bus.req = vecs[v].req;
      for (int g = 0; g < $countones(vecs[v].req); g++)
        serve_one(g < $countones(vecs[v].req) - 1);
      @(negedge clk);
    end

    // stale finish: FSM must hold in ARM while finish is still high
    stale_fin     = 1'b1;
    bus.req_times = {4'd0, 4'd0, 4'd2};
    push_grants(3'b001, bus.req_times);
    bus.req = 3'b001;
    repeat (6) @(negedge clk);
    chk("stale_no_ack", int'(bus.ack), 0);
    chk("stale_hold_start", int'(bus.dly_start), 1);
    stale_fin = 1'b0;
    serve_one(1'b0);
    @(negedge clk);

    bus.req_times = {4'd1, 4'd0, 4'd0};
    push_grants(3'b100, bus.req_times);
    bus.req = 3'b100;
    serve_one(1'b0);
    @(negedge clk);

    // fairness: req0 re-raised right after its ack loses to pending req2
    bus.req_times = {4'd2, 4'd0, 4'd1};
    sbq.push_back('{0, 4'd1});
    bus.req = 3'b101;
    serve_one(1'b0);
    bus.req[0] = 1'b1;
    sbq.push_back('{2, 4'd2});
    sbq.push_back('{0, 4'd1});
    serve_one(1'b1);
    serve_one(1'b0);
    @(negedge clk);

    // req dropped before ack; late req_times change must not leak in
    bus.req_times = {4'd0, 4'd3, 4'd0};
    bus.req = 3'b010;
    wait_busy();
    bus.req       = 3'b000;
    bus.req_times = '1;
    @(negedge clk);
    chk("times_frozen", int'(bus.dly_times), 3);
    wait_ack(ok);
    if (ok) begin
      chk("viol_ack", int'(bus.ack), 3'b010);
      @(negedge clk);
      chk("viol_ack_pulse", int'(bus.ack), 0);
      chk("viol_idle", int'(bus.busy), 0);
    end
    ptr_m = 2;
    @(negedge clk);

    // async reset in RUN, then pointer must be back at 0
    bus.req_times = {4'd8, 4'd0, 4'd0};
    bus.req = 3'b100;
    wait_busy();
    repeat (3) @(negedge clk);
    chk("run_start", int'(bus.dly_start), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_run_start", int'(bus.dly_start), 0);
    chk("rst_run_ack", int'(bus.ack), 0);
    chk("rst_run_busy", int'(bus.busy), 0);
    bus.req = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);
    bus.req_times = {4'd1, 4'd2, 4'd3};
    push_grants(3'b111, bus.req_times);
    bus.req = 3'b111;
    serve_one(1'b1);
    serve_one(1'b1);
    serve_one(1'b0);
    @(negedge clk);

`ifdef SD_DLY_TIMEOUT_EN
    stuck = 1'b1;
    bus.req_times = '0;
    bus.req = 3'b001;
    wait_busy();
    n = 0;
    while (bus.ack == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 20);
    chk("timeout_err", int'(bus.err), 1);
    chk("timeout_ack", int'(bus.ack), 1);
    bus.req = 3'b000;
    stuck = 1'b0;
    @(negedge clk);
    chk("timeout_ack_drop", int'(bus.ack), 0);
    chk("err_sticky", int'(bus.err), 1);
`else
    n = 0;
    chk("err_tied_low", int'(bus.err) + n, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
